screen_dump_tx: RTL and testbench

- Reads the text buffer back out of the dual-port character RAM and transmits it over the UART TX line. The buffer is 4 rows × 32 columns of 7-bit ASCII.
- This is the reverse path of the RX-to-RAM writer: on a start pulse it scans every cell, serialises each byte as 8N1, and appends CR LF after every row.
- It sits beside the VGA read port, on the RAM's second read port or a muxed one, and drives RsTx directly.

---
 rtl/screen_dump_tx.sv | 165 ++++++++++++++++
 tb/tb_screen_dump_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_dump_tx.sv
// screen_dump_tx
//   Dumps the 4x32 character buffer out of the dual-port text RAM over the UART TX line.
//   Each cell is read, sanitised to printable 7-bit ASCII and sent as one 8N1 frame.
//   CR LF is appended after every row.
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-low reset
//   start    single-cycle dump request (ignored while busy)
//   rd_row   RAM read row address
//   rd_col   RAM read column address
//   rd_data  RAM read data, valid one clk after the address
//   tx       UART serial out, idle high
//   busy     dump in progress
//   done     one-cycle pulse after the final LF stop bit
module screen_dump_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int ROWS      = 4,
  parameter int COLS      = 32,
  parameter int ROW_W     = 2,
  parameter int COL_W     = 5,
  parameter int COL_START = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  input  logic [7:0]       rd_data,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(COL_START);
  localparam logic [3:0]        BIT_STOP  = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_CR    = 3'd4;
  localparam logic [2:0] S_LF    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_i;     // scan index i; the sent column is COL_START + i
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop bit
  logic [7:0]        shift;     // d0 always sits in shift[0] while data bits go out

  logic [7:0] raw;
  logic       is_ctrl;
  logic [7:0] latch_byte;
  logic       in_frame;

  // The row/col registers only change on entry to FETCH, so the address is
  // presented throughout FETCH and otherwise holds its last value.
  assign rd_row = row_q;
  assign rd_col = COL_FIRST + col_i;   // wraps mod 2^COL_W

  assign in_frame = (state == S_SEND) || (state == S_CR) || (state == S_LF);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

  // Bit 7 is never transmitted; control codes and DEL become '.'.
  assign raw        = rd_data & 8'h7F;
  assign is_ctrl    = (raw < 8'h20) || (raw == 8'h7F);
  assign latch_byte = is_ctrl ? 8'h2E : raw;

  // tx is decoded from state so an asynchronous reset forces it high at once.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx = 1'b1;
    if (in_frame) begin
      if (bit_idx == 4'd0)          tx = 1'b0;
      else if (bit_idx == BIT_STOP) tx = 1'b1;
      else                          tx = shift[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      row_q    <= '0;
      col_i    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row_q <= '0;
            col_i <= '0;
            state <= S_FETCH;
          end
        end

        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          shift    <= latch_byte;
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= S_SEND;
        end

        S_SEND, S_CR, S_LF: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_idx != BIT_STOP) begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx != 4'd0) shift <= shift >> 1;
            end else begin
              // Frame complete. CR and LF follow back-to-back with no gap;
              // the FETCH/LATCH pair provides the only inter-frame idle time.
              bit_idx <= '0;
              case (state)
                S_SEND: begin
                  if (col_i == COL_LAST) begin
                    shift <= 8'h0D;
                    state <= S_CR;
                  end else begin
                    col_i <= col_i + 1'b1;
                    state <= S_FETCH;
                  end
                end
                S_CR: begin
                  shift <= 8'h0A;
                  state <= S_LF;
                end
                default: begin
                  if (row_q == ROW_LAST) begin
                    state <= S_DONE;
                  end else begin
                    row_q <= row_q + 1'b1;
                    col_i <= '0;
                    state <= S_FETCH;
                  end
                end
              endcase
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_dump_tx.sv
// tb_screen_dump_tx
//   Directed bench for screen_dump_tx at CLK_FREQ=1000, BAUD=100 (10 clks per bit).
//   A behavioural RAM returns data one clk after the address; tx is decoded by
//   sampling mid-bit on the falling clock edge.
module tb_screen_dump_tx;

  localparam int ROWS      = 4;
  localparam int COLS      = 32;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 5;
  localparam int COL_START = 24;
  localparam int NBYTES    = ROWS * (COLS + 2);

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [7:0]       rd_data;
  logic             tx;
  logic             busy;
  logic             done;

  logic [7:0] mem [ROWS][32];
  logic [7:0] exp_stream [NBYTES];

  int n_assert = 0;
  int n_fail   = 0;
  int busy_low = 0;
  int done_cnt = 0;

  screen_dump_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W),
    .COL_START(COL_START)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_row][rd_col];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expect_char(input logic [7:0] v);
    logic [6:0] c;
    c = v[6:0];
    if ((c < 7'h20) || (c == 7'h7F)) return 8'h2E;
    return {1'b0, c};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_tx_low(input string tag);
    int waited;
    waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(waited < 400), 1);
  endtask

  // Decode one 8N1 frame; returns once the stop bit has been sampled mid-bit.
  task automatic rx_byte(output logic [7:0] b);
    logic [9:0] f;
    wait_tx_low("rx_start_seen");
    repeat (5) @(negedge clk);
    f[0] = tx;
    if (busy !== 1'b1) busy_low++;
    for (int k = 1; k < 10; k++) begin
      repeat (10) @(negedge clk);
      f[k] = tx;
      if (busy !== 1'b1) busy_low++;
    end
    check("framing", {30'd0, f[9], f[0]}, 2'b10);
    b = f[8:1];
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] frame;
    int         bad;
    int         idx;
    int         done_before;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 8'(32'h20 + ((r * 32 + c) % 95));
    mem[0][24] = 8'h41;

    idx = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < COLS; i++)
        exp_stream[idx++] = expect_char(mem[r][(COL_START + i) % 32]);
      exp_stream[idx++] = 8'h0D;
      exp_stream[idx++] = 8'h0A;
    end

    // ---- reset held: outputs at reset values, start ignored ----
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_row", rd_row, 0);
    check("rst_col", rd_col, 24);
    bad = 0;
    start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("rst_quiet", bad, 0);
    reset = 1'b1;
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);

    // ---- full dump, exact first frame, start while busy ----
    done_before = done_cnt;
    pulse_start();
    check("fetch_row", rd_row, 0);
    check("fetch_col", rd_col, 24);
    check("busy_on", busy, 1);
    wait_tx_low("first_start_seen");
    frame = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < 10; j++) begin
        if (tx !== frame[k]) bad++;
        if (busy !== 1'b1) busy_low++;
        @(negedge clk);
      end
      check($sformatf("frame_bit%0d", k), bad, 0);
    end
    bad = 0;
    while (tx === 1'b1 && bad < 20) begin
      bad++;
      @(negedge clk);
    end
    check("frame_gap", bad, 2);
    for (int n = 1; n < NBYTES; n++) begin
      rx_byte(b);
      check($sformatf("byte%0d", n), b, exp_stream[n]);
      if (n == 9) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    bad = 0;
    while (done !== 1'b1 && bad < 30) begin
      @(negedge clk);
      bad++;
    end
    check("done_seen", 32'(bad < 30), 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_single", done, 0);
    repeat (40) @(negedge clk);
    check("one_done", done_cnt - done_before, 1);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("busy_during_dump", busy_low, 0);
    check("hold_row", rd_row, 3);
    check("hold_col", rd_col, 23);

    // ---- substitution, then reset during a data bit ----
    mem[0][24] = 8'h00;
    mem[0][25] = 8'h1F;
    mem[0][26] = 8'h7F;
    mem[0][27] = 8'hC1;
    mem[0][28] = 8'h40;
    done_before = done_cnt;
    pulse_start();
    check("fetch2_row", rd_row, 0);
    check("fetch2_col", rd_col, 24);
    rx_byte(b); check("sub_00", b, 8'h2E);
    rx_byte(b); check("sub_1f", b, 8'h2E);
    rx_byte(b); check("sub_7f", b, 8'h2E);
    rx_byte(b); check("sub_c1", b, 8'h41);
    wait_tx_low("fifth_start_seen");
    repeat (15) @(negedge clk);
    check("mid_d0_low", tx, 0);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    bad = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("no_resume", bad, 0);
    check("no_done_after_abort", done_cnt - done_before, 0);

    // ---- fresh dump after abort restarts at row 0, col 24 ----
    pulse_start();
    check("fetch3_row", rd_row, 0);
    check("fetch3_col", rd_col, 24);
    check("busy3_on", busy, 1);
    rx_byte(b); check("fresh_b0", b, 8'h2E);
    rx_byte(b); check("fresh_b1", b, 8'h2E);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
